// File: rtl/simple_multi_axil_core_pkg.sv
// Shared register map, CTRL bit positions and engine state type for the simple_multi AXI-Lite block.
package simple_multi_pkg;

  localparam int AXI_DW = 32;

  localparam logic [3:0] OPA_OFS    = 4'h0;
  localparam logic [3:0] OPB_OFS    = 4'h4;
  localparam logic [3:0] CTRL_OFS   = 4'h8;
  localparam logic [3:0] RESULT_OFS = 4'hC;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;
  localparam int CTRL_IE_BIT    = 2;
  localparam int CTRL_BUSY_BIT  = 8;

  typedef enum logic [0:0] {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_t;

  // Byte-lane merge of a bus write into a stored register.
  function automatic logic [AXI_DW-1:0] apply_wstrb(input logic [AXI_DW-1:0] old_val,
                                                    input logic [AXI_DW-1:0] new_val,
                                                    input logic [AXI_DW/8-1:0] strb);
    logic [AXI_DW-1:0] res;
    res = old_val;
    for (int i = 0; i < AXI_DW / 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/simple_multi_axil_core_if.sv
// AXI4-Lite channel bundle for the S00_AXI port; master drives requests, slave drives ready/response.
interface simple_multi_axil_core_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/simple_multi_axil_core_shift_add.sv
// Sequential shift-add multiplier: one partial product per cycle, product valid with done_pulse_o
// OP_WIDTH cycles after the start edge; start_i is ignored while busy.
module simple_multi_shift_add
  import simple_multi_pkg::*;
#(
  parameter int OP_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [OP_WIDTH-1:0]   opa_i,
  input  logic [OP_WIDTH-1:0]   opb_i,
  output logic                  busy_o,
  output logic                  done_pulse_o,
  output logic [2*OP_WIDTH-1:0] product_o
);
  localparam int PW = 2 * OP_WIDTH;
  localparam int CW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(OP_WIDTH - 1);

  mul_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       mcand_q, mcand_d;
  logic [PW-1:0]       acc_q, acc_d, acc_sum;
  logic [OP_WIDTH-1:0] mplier_q, mplier_d;

  // The sum for the current iteration doubles as the final product on the last one.
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product_o = acc_sum;
  assign busy_o    = (state_q == MUL_RUN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    done_pulse_o = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          state_d  = MUL_RUN;
          cnt_d    = '0;
          mcand_d  = PW'(opa_i);
          mplier_d = opb_i;
          acc_d    = '0;
        end
      end
      MUL_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          done_pulse_o = 1'b1;
          state_d      = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

endmodule

// File: rtl/simple_multi_axil_core.sv
// AXI4-Lite register block (OPA/OPB/CTRL/RESULT) around the shift-add engine; single outstanding
// read and write, each responding one cycle after its handshake. SIMPLE_MULTI_IRQ_EN adds CTRL.ie and irq.
module simple_multi_axil_core
  import simple_multi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int OP_WIDTH           = 16
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  simple_multi_axil_core_if.slave s00_axi
`ifdef SIMPLE_MULTI_IRQ_EN
  ,
  output logic                    irq
`endif
);
  localparam int DW = C_S_AXI_DATA_WIDTH;

  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic [1:0]            wsel, rsel;
  logic                  wr_hs, rd_hs, ctrl_wr, start_acc;
  logic [DW-1:0]         opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [DW-1:0]         rdata_q, rdata_d, ctrl_rd, rd_mux;
  logic                  done_q, done_d, bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic                  busy, done_pulse;
  logic [2*OP_WIDTH-1:0] product;
  logic                  unused_sig;

  assign awaddr    = s00_axi.awaddr;
  assign araddr    = s00_axi.araddr;
  assign wsel      = awaddr[3:2];
  assign rsel      = araddr[3:2];
  assign wr_hs     = s00_axi.awvalid && s00_axi.wvalid && !bvalid_q;
  assign rd_hs     = s00_axi.arvalid && !rvalid_q;
  assign ctrl_wr   = wr_hs && (wsel == CTRL_OFS[3:2]) && s00_axi.wstrb[0];
  assign start_acc = ctrl_wr && s00_axi.wdata[CTRL_START_BIT] && !busy;
  assign unused_sig = ^{s00_axi.awprot, s00_axi.arprot, awaddr, araddr};

  simple_multi_shift_add #(.OP_WIDTH(OP_WIDTH)) u_engine (
    .clk_i       (s00_axi_aclk),
    .rst_ni      (s00_axi_aresetn),
    .start_i     (start_acc),
    .opa_i       (opa_q[OP_WIDTH-1:0]),
    .opb_i       (opb_q[OP_WIDTH-1:0]),
    .busy_o      (busy),
    .done_pulse_o(done_pulse),
    .product_o   (product)
  );

`ifdef SIMPLE_MULTI_IRQ_EN
  logic ie_q, ie_d, irq_q;
  assign ie_d = ctrl_wr ? s00_axi.wdata[CTRL_IE_BIT] : ie_q;
  assign irq  = irq_q;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= done_d && ie_d;
    end
  end
`endif

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_DONE_BIT] = done_q;
    ctrl_rd[CTRL_BUSY_BIT] = busy;
`ifdef SIMPLE_MULTI_IRQ_EN
    ctrl_rd[CTRL_IE_BIT] = ie_q;
`endif
    case (rsel)
      OPA_OFS[3:2]:  rd_mux = opa_q;
      OPB_OFS[3:2]:  rd_mux = opb_q;
      CTRL_OFS[3:2]: rd_mux = ctrl_rd;
      default:       rd_mux = result_q;
    endcase
  end

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    done_d   = done_q;
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (wr_hs && wsel == OPA_OFS[3:2]) opa_d = apply_wstrb(opa_q, s00_axi.wdata, s00_axi.wstrb);
    if (wr_hs && wsel == OPB_OFS[3:2]) opb_d = apply_wstrb(opb_q, s00_axi.wdata, s00_axi.wstrb);
    // Completion beats a same-cycle clear so a finished result is never silently lost.
    if (done_pulse) begin
      result_d = DW'(product);
      done_d   = 1'b1;
    end else if (ctrl_wr && s00_axi.wdata[CTRL_DONE_BIT]) begin
      done_d = 1'b0;
    end
    if (start_acc) done_d = 1'b0;
    if (wr_hs) bvalid_d = 1'b1;
    else if (s00_axi.bready) bvalid_d = 1'b0;
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (s00_axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      done_q   <= done_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign s00_axi.awready = wr_hs;
  assign s00_axi.wready  = wr_hs;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = rd_hs;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = 2'b00;

endmodule

// File: tb/tb_simple_multi_axil_core.sv
// Directed bench for simple_multi_axil_core: vector table plus cycle-exact multiply sequences.
module tb_simple_multi_axil_core;
  logic clk;
  logic rst_n;
  int   cyc;
  int   vecs;
  int   miscompares;
  int   last_wr_cyc;

  simple_multi_axil_core_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

`ifdef SIMPLE_MULTI_IRQ_EN
  logic irq;
`endif

  simple_multi_axil_core #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .OP_WIDTH(16)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi        (bus)
`ifdef SIMPLE_MULTI_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          pre_wait;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  function automatic vec_t mk(bit wr, logic [3:0] a, logic [31:0] d, logic [3:0] s, int w, logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.pre_wait = w; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    vecs++;
    miscompares++;
    $display("FAIL timeout waiting for %s", name);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) note_timeout("awready/wready");
    @(posedge clk); #1;
    last_wr_cyc = cyc;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) note_timeout("bvalid");
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  // at_cyc > 0 places the address handshake exactly on posedge number at_cyc.
  task automatic axi_read(input logic [3:0] a, input int at_cyc, output logic [31:0] d);
    int n;
    @(negedge clk);
    if (at_cyc > 0) begin
      while (cyc < at_cyc - 1) @(negedge clk);
      chk("read_schedule", cyc, at_cyc - 1);
    end
    bus.araddr = a; bus.arvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) note_timeout("arready");
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    n = 0;
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) note_timeout("rvalid");
    d = bus.rdata;
    chk("rresp", {30'b0, bus.rresp}, 32'h0);
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awready"}, {31'b0, bus.awready}, 32'h0);
    chk({tag, "_wready"},  {31'b0, bus.wready},  32'h0);
    chk({tag, "_bvalid"},  {31'b0, bus.bvalid},  32'h0);
    chk({tag, "_arready"}, {31'b0, bus.arready}, 32'h0);
    chk({tag, "_rvalid"},  {31'b0, bus.rvalid},  32'h0);
    chk({tag, "_rdata"},   bus.rdata,            32'h0);
    chk({tag, "_resp"},    {28'b0, bus.bresp, bus.rresp}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] rd, rd2;
    logic [1:0]  resp, resp2;
    int t0;
    vecs = 0; miscompares = 0; cyc = 0; last_wr_cyc = 0;
    rst_n = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    vt[0]  = mk(0, 4'h0, 32'h0, 4'h0, 0, 32'h0);
    vt[1]  = mk(0, 4'h4, 32'h0, 4'h0, 0, 32'h0);
    vt[2]  = mk(0, 4'h8, 32'h0, 4'h0, 0, 32'h0);
    vt[3]  = mk(0, 4'hC, 32'h0, 4'h0, 0, 32'h0);
    vt[4]  = mk(1, 4'h0, 32'h1, 4'hF, 0, 32'h0);
    vt[5]  = mk(1, 4'h4, 32'h2, 4'hF, 0, 32'h0);
    vt[6]  = mk(1, 4'h8, 32'h3, 4'hF, 0, 32'h0);
    vt[7]  = mk(1, 4'hC, 32'h4, 4'hF, 0, 32'h0);
    vt[8]  = mk(0, 4'h0, 32'h0, 4'h0, 0, 32'h1);
    vt[9]  = mk(0, 4'h4, 32'h0, 4'h0, 0, 32'h2);
    vt[10] = mk(0, 4'h8, 32'h0, 4'h0, 0, 32'h100);
    vt[11] = mk(0, 4'hC, 32'h0, 4'h0, 0, 32'h0);
    vt[12] = mk(0, 4'hC, 32'h0, 4'h0, 20, 32'h2);
    vt[13] = mk(0, 4'h8, 32'h0, 4'h0, 0, 32'h2);
    vt[14] = mk(1, 4'h8, 32'h2, 4'hF, 0, 32'h0);
    vt[15] = mk(0, 4'h8, 32'h0, 4'h0, 0, 32'h0);
    vt[16] = mk(1, 4'h0, 32'hAABBCCDD, 4'hF, 0, 32'h0);
    vt[17] = mk(1, 4'h1, 32'h12340002, 4'h1, 0, 32'h0);
    vt[18] = mk(0, 4'h0, 32'h0, 4'h0, 0, 32'hAABBCC02);
    vt[19] = mk(1, 4'h4, 32'h11223344, 4'hA, 0, 32'h0);
    vt[20] = mk(0, 4'h4, 32'h0, 4'h0, 0, 32'h11003302);

    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      repeat (vt[i].pre_wait) @(posedge clk);
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, resp);
        chk($sformatf("vec%0d_bresp", i), {30'b0, resp}, vt[i].exp);
      end else begin
        axi_read(vt[i].addr, 0, rd);
        chk($sformatf("vec%0d_rdata@%0h", i, vt[i].addr), rd, vt[i].exp);
      end
    end

    // 3 * 5 with edge-exact observation of busy, done and RESULT.
    axi_write(4'h0, 32'd3, 4'hF, resp);
    axi_write(4'h4, 32'd5, 4'hF, resp);
    axi_write(4'h8, 32'h1, 4'hF, resp);
    t0 = last_wr_cyc;
    axi_read(4'h8, 0, rd);        chk("mulA_busy", rd, 32'h100);
    axi_read(4'hC, 0, rd);        chk("mulA_result_old", rd, 32'h2);
    axi_read(4'h8, t0 + 15, rd);  chk("mulA_ctrl_t15", rd, 32'h100);
    axi_read(4'h8, t0 + 17, rd);  chk("mulA_ctrl_t17", rd, 32'h2);
    axi_read(4'hC, 0, rd);        chk("mulA_result", rd, 32'hF);
    axi_write(4'h8, 32'h2, 4'hF, resp);
    axi_read(4'h8, 0, rd);        chk("mulA_done_clr", rd, 32'h0);

    // Max operands; CTRL read on the done-setting edge sees the old value.
    axi_write(4'h0, 32'hFFFF, 4'hF, resp);
    axi_write(4'h4, 32'hFFFF, 4'hF, resp);
    axi_write(4'h8, 32'h1, 4'hF, resp);
    t0 = last_wr_cyc;
    axi_read(4'h8, t0 + 16, rd);  chk("mulB_ctrl_t16", rd, 32'h100);
    axi_read(4'hC, 0, rd);        chk("mulB_result", rd, 32'hFFFE0001);
    axi_read(4'h8, 0, rd);        chk("mulB_ctrl_done", rd, 32'h2);

    // Operand rewrite and restart while running must not disturb the multiply.
    axi_write(4'h0, 32'd7, 4'hF, resp);
    axi_write(4'h4, 32'd9, 4'hF, resp);
    axi_write(4'h8, 32'h1, 4'hF, resp);
    axi_write(4'h0, 32'h100, 4'hF, resp);
    axi_write(4'h8, 32'h1, 4'hF, resp);
    chk("mulC_busy_start_bresp", {30'b0, resp}, 32'h0);
    axi_read(4'h8, 0, rd);        chk("mulC_busy", rd, 32'h100);
    repeat (20) @(posedge clk);
    axi_read(4'hC, 0, rd);        chk("mulC_result", rd, 32'h3F);
    axi_read(4'h8, 0, rd);        chk("mulC_done", rd, 32'h2);
    axi_write(4'h8, 32'h2, 4'hF, resp);
    repeat (30) @(posedge clk);
    axi_read(4'h8, 0, rd);        chk("mulC_done_once", rd, 32'h0);
    axi_read(4'hC, 0, rd);        chk("mulC_result_kept", rd, 32'h3F);

    // start and done written together: start wins.
    axi_write(4'h8, 32'h1, 4'hF, resp);
    repeat (20) @(posedge clk);
    axi_read(4'h8, 0, rd);        chk("mulD_done", rd, 32'h2);
    axi_write(4'h8, 32'h3, 4'hF, resp);
    axi_read(4'h8, 0, rd);        chk("mulD_start_wins", rd, 32'h100);
    repeat (20) @(posedge clk);
    axi_read(4'hC, 0, rd);        chk("mulD_result", rd, 32'h900);
    axi_read(4'h8, 0, rd);        chk("mulD_done2", rd, 32'h2);

    // Read and write accepted in the same cycle; the read sees the pre-write value.
    fork
      axi_write(4'h4, 32'h77, 4'hF, resp2);
      axi_read(4'h4, 0, rd2);
    join
    chk("simul_bresp", {30'b0, resp2}, 32'h0);
    chk("simul_read_old", rd2, 32'h9);
    axi_read(4'h4, 0, rd);        chk("simul_read_new", rd, 32'h77);

`ifdef SIMPLE_MULTI_IRQ_EN
    chk("irq_ie0", {31'b0, irq}, 32'h0);
    axi_write(4'h8, 32'h4, 4'hF, resp);
    chk("irq_ie1", {31'b0, irq}, 32'h1);
    axi_read(4'h8, 0, rd);        chk("irq_ctrl", rd, 32'h6);
    axi_write(4'h8, 32'h6, 4'hF, resp);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    axi_read(4'h8, 0, rd);        chk("irq_ctrl_ie", rd, 32'h4);
`else
    axi_write(4'h8, 32'h4, 4'hF, resp);
    axi_read(4'h8, 0, rd);        chk("ie_absent", rd, 32'h2);
`endif

    // Reset five edges into a multiply aborts it completely.
    axi_write(4'h8, 32'h1, 4'hF, resp);
    t0 = last_wr_cyc;
    while (cyc < t0 + 5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrun_reset");
`ifdef SIMPLE_MULTI_IRQ_EN
    chk("midrun_irq", {31'b0, irq}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(4'h8, 0, rd);        chk("rst_ctrl", rd, 32'h0);
    axi_read(4'hC, 0, rd);        chk("rst_result", rd, 32'h0);
    axi_read(4'h0, 0, rd);        chk("rst_opa", rd, 32'h0);
    repeat (25) @(posedge clk);
    axi_read(4'h8, 0, rd);        chk("rst_ctrl_late", rd, 32'h0);
    axi_read(4'hC, 0, rd);        chk("rst_result_late", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
